n64_audio_i2s_tx: RTL

//  Downstream of the N64 I2S sampler. Takes its 16-bit stereo pairs (APDATA_*/VALID) and buffers

---
 rtl/n64_audio_i2s_tx_if.sv | 19 +
 rtl/n64_audio_i2s_tx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/n64_audio_i2s_tx_if.sv
// Stereo sample bus from the N64 I2S sampler.
// One valid strobe qualifies a left/right pair.
interface n64_audio_i2s_tx_if;
  logic [15:0] APDATA_LEFT_i;
  logic [15:0] APDATA_RIGHT_i;
  logic        APDATA_VALID_i;

  modport master (
    output APDATA_LEFT_i,
    output APDATA_RIGHT_i,
    output APDATA_VALID_i
  );

  modport slave (
    input APDATA_LEFT_i,
    input APDATA_RIGHT_i,
    input APDATA_VALID_i
  );
endinterface

// File: rtl/n64_audio_i2s_tx.sv
// Buffers N64 stereo pairs and re-serialises them
// as Philips I2S timed purely from AMCLK.
module n64_audio_i2s_tx #(
  parameter int MCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic             AMCLK_i,
  input  logic             ARST,
  input  logic             EN_i,
  input  logic             CLR_FLAGS_i,
  n64_audio_i2s_tx_if.slave ap,
  output logic             ASCLK_o,
  output logic             ALRCLK_o,
  output logic             ASDATA_o,
  output logic [LVL_W-1:0] FIFO_LEVEL_o,
  output logic             UNDERRUN_o,
  output logic             OVERFLOW_o
);

  localparam int DIV_W = $clog2(MCLK_DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DMAX =
    DIV_W'(MCLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF =
    DIV_W'(MCLK_DIV / 2);
  localparam logic [LVL_W-1:0] FULL =
    LVL_W'(FIFO_DEPTH);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [5:0]       bit_cnt;
  logic [5:0]       bit_nxt;
  logic             started;
  logic             tick;
  logic             frame0;
  logic [15:0]      out_l;
  logic [15:0]      out_r;
  logic [3:0]       sidx;
  logic             ser_bit;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             flush;
  logic             pop;
  logic             push;
  logic             ur_set;
  logic             of_set;

  // The first enabled edge starts a frame at once;
  // afterwards a new bit begins on each divider wrap.
  always_comb begin
    tick    = EN_i && (!started || div_cnt == DMAX);
    div_nxt = tick ? '0 : div_cnt + DIV_W'(1);
    bit_nxt = started ? bit_cnt + 6'd1 : 6'd0;
    frame0  = tick && bit_nxt == 6'd0;
    empty   = FIFO_LEVEL_o == '0;
    full    = FIFO_LEVEL_o == FULL;
    flush   = !EN_i && started;
    pop     = frame0 && !empty;
    ur_set  = frame0 && empty;
    push    = ap.APDATA_VALID_i && !flush &&
              (!full || pop);
    of_set  = ap.APDATA_VALID_i && !flush &&
              full && !pop;
  end

  // Slot n of a word carries bit (16-n); the
  // right word sits 32 slots later, same low bits.
  always_comb begin
    sidx    = 4'd0 - bit_nxt[3:0];
    ser_bit = 1'b0;
    unique case (1'b1)
      (bit_nxt >= 6'd1 && bit_nxt <= 6'd16):
        ser_bit = out_l[sidx];
      (bit_nxt >= 6'd33 && bit_nxt <= 6'd48):
        ser_bit = out_r[sidx];
      default: ser_bit = 1'b0;
    endcase
  end

  // Bit clock, frame counter and serial outputs.
  always_ff @(posedge AMCLK_i or posedge ARST) begin
    if (ARST) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      started  <= 1'b0;
      ASCLK_o  <= 1'b0;
      ALRCLK_o <= 1'b1;
      ASDATA_o <= 1'b0;
      out_l    <= '0;
      out_r    <= '0;
    end else if (!EN_i) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      started  <= 1'b0;
      ASCLK_o  <= 1'b0;
      ALRCLK_o <= 1'b1;
      ASDATA_o <= 1'b0;
      out_l    <= '0;
      out_r    <= '0;
    end else begin
      started <= 1'b1;
      div_cnt <= div_nxt;
      ASCLK_o <= div_nxt >= HALF;
      if (tick) begin
        bit_cnt  <= bit_nxt;
        ASDATA_o <= ser_bit;
        if (bit_nxt == 6'd0) ALRCLK_o <= 1'b0;
        if (bit_nxt == 6'd32) ALRCLK_o <= 1'b1;
        if (pop) begin
          out_l <= mem[rd_ptr][31:16];
          out_r <= mem[rd_ptr][15:0];
        end
      end
    end
  end

  // FIFO storage array.
  always_ff @(posedge AMCLK_i) begin
    if (push)
      mem[wr_ptr] <= {ap.APDATA_LEFT_i,
                      ap.APDATA_RIGHT_i};
  end

  // FIFO pointers and level; flushed on disable.
  always_ff @(posedge AMCLK_i or posedge ARST) begin
    if (ARST) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      FIFO_LEVEL_o <= '0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      FIFO_LEVEL_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        FIFO_LEVEL_o <= FIFO_LEVEL_o + LVL_W'(1);
      else if (pop && !push)
        FIFO_LEVEL_o <= FIFO_LEVEL_o - LVL_W'(1);
    end
  end

  // Sticky error flags; a new event beats a clear.
  always_ff @(posedge AMCLK_i or posedge ARST) begin
    if (ARST) begin
      UNDERRUN_o <= 1'b0;
      OVERFLOW_o <= 1'b0;
    end else begin
      UNDERRUN_o <= ur_set |
                    (UNDERRUN_o & ~CLR_FLAGS_i);
      OVERFLOW_o <= of_set |
                    (OVERFLOW_o & ~CLR_FLAGS_i);
    end
  end

endmodule
